load_store_unit: RTL and testbench

- Memory-stage load/store unit between the pipelined core's memory stage and an external data-memory bus with a valid/ready handshake.
- Consumes the memory-stage address (ALUOutM), store data (WriteDataM) and access controls, and produces ReadDataM for the writeback register.
- Holds the pipeline via MemStallM while a bus access is outstanding.
- Supports word and byte accesses and handles misalignment, bus errors and timeout.

---
 rtl/load_store_unit.sv | 165 ++++++++++++++++
 tb/tb_load_store_unit.sv | 325 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/load_store_unit.sv
// Memory-stage load/store unit: turns M-stage load/store requests into single
// valid/ready bus transactions, stalls the pipeline while one is outstanding,
// and reports misalignment, bus errors and timeouts as a one-cycle ErrorM pulse.
module load_store_unit #(
   parameter int unsigned TIMEOUT = 255,
   parameter int unsigned TO_W    = 8
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        MemReqM,
   input  logic        MemWriteM,
   input  logic        ByteOpM,
   input  logic [31:0] ALUOutM,
   input  logic [31:0] WriteDataM,
   output logic [31:0] ReadDataM,
   output logic        MemStallM,
   output logic        ErrorM,
   output logic [31:0] BusAddr,
   output logic [31:0] BusWData,
   output logic [3:0]  BusBE,
   output logic        BusWrite,
   output logic        BusValid,
   input  logic        BusReady,
   input  logic [31:0] BusRData,
   input  logic        BusErr
);

   typedef enum logic [1:0] {StIdle, StAccess, StDone} state_e;

   state_e          state_q, state_d;
   logic [TO_W-1:0] cnt_q, cnt_d;
   logic [31:0]     addr_q, addr_d;
   logic [31:0]     wdata_q, wdata_d;
   logic [3:0]      be_q, be_d;
   logic            write_q, write_d;
   logic            byte_q, byte_d;
   logic            err_q, err_d;
   logic [31:0]     rdata_q, rdata_d;

   logic            bus_valid;
   logic            stall;
   logic            error;
   logic [31:0]     rdata_shift;
   logic [7:0]      rdata_lane;

   // Selected byte lane of the returned read data for byte loads.
   always_comb begin
      rdata_shift = BusRData >> {addr_q[1:0], 3'b000};
      rdata_lane  = rdata_shift[7:0];
   end

   // Next-state, latched-request updates and combinational outputs.
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      addr_d    = addr_q;
      wdata_d   = wdata_q;
      be_d      = be_q;
      write_d   = write_q;
      byte_d    = byte_q;
      err_d     = err_q;
      rdata_d   = rdata_q;
      bus_valid = 1'b0;
      stall     = 1'b0;
      error     = 1'b0;

      unique case (state_q)
         StIdle: begin
            stall = MemReqM;
            if (MemReqM) begin
               write_d = MemWriteM;
               byte_d  = ByteOpM;
               if (ByteOpM) begin
                  addr_d  = ALUOutM;
                  be_d    = 4'b0001 << ALUOutM[1:0];
                  wdata_d = {4{WriteDataM[7:0]}};
               end else begin
                  addr_d  = {ALUOutM[31:2], 2'b00};
                  be_d    = 4'b1111;
                  wdata_d = WriteDataM;
               end
               if (!ByteOpM && (ALUOutM[1:0] != 2'b00)) begin
                  // Misaligned word: complete with error, never touch the bus.
                  err_d   = 1'b1;
                  rdata_d = 32'h0;
                  state_d = StDone;
               end else begin
                  err_d   = 1'b0;
                  cnt_d   = '0;
                  state_d = StAccess;
               end
            end
         end
         StAccess: begin
            bus_valid = 1'b1;
            stall     = 1'b1;
            if (BusReady) begin
               err_d = BusErr;
               if (BusErr || write_q) begin
                  rdata_d = 32'h0;
               end else if (byte_q) begin
                  rdata_d = {24'h0, rdata_lane};
               end else begin
                  rdata_d = BusRData;
               end
               state_d = StDone;
            end else if (cnt_q == TO_W'(TIMEOUT - 1)) begin
               err_d   = 1'b1;
               rdata_d = 32'h0;
               state_d = StDone;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         StDone: begin
            // MemReqM here still belongs to the instruction just completed.
            error   = err_q;
            state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase

      // Reset cycle forces the handshake and stall quiet regardless of state.
      if (!reset) begin
         bus_valid = 1'b0;
         stall     = 1'b0;
         error     = 1'b0;
      end
   end

   // State and latched-request registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q <= StIdle;
         cnt_q   <= '0;
         addr_q  <= 32'h0;
         wdata_q <= 32'h0;
         be_q    <= 4'h0;
         write_q <= 1'b0;
         byte_q  <= 1'b0;
         err_q   <= 1'b0;
         rdata_q <= 32'h0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         be_q    <= be_d;
         write_q <= write_d;
         byte_q  <= byte_d;
         err_q   <= err_d;
         rdata_q <= rdata_d;
      end
   end

   assign ReadDataM = rdata_q;
   assign MemStallM = stall;
   assign ErrorM    = error;
   assign BusAddr   = addr_q;
   assign BusWData  = wdata_q;
   assign BusBE     = be_q;
   assign BusWrite  = write_q;
   assign BusValid  = bus_valid;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed self-checking bench for load_store_unit (TIMEOUT=4).
// Inputs change just after the falling edge; outputs are sampled 1ns later.
module tb_load_store_unit;

   logic        clk = 1'b0;
   logic        reset;
   logic        MemReqM, MemWriteM, ByteOpM;
   logic [31:0] ALUOutM, WriteDataM;
   logic [31:0] ReadDataM;
   logic        MemStallM, ErrorM;
   logic [31:0] BusAddr, BusWData;
   logic [3:0]  BusBE;
   logic        BusWrite, BusValid;
   logic        BusReady;
   logic [31:0] BusRData;
   logic        BusErr;

   int n_checks = 0;
   int n_fail   = 0;

   load_store_unit #(.TIMEOUT(4), .TO_W(8)) dut (
      .clk(clk), .reset(reset),
      .MemReqM(MemReqM), .MemWriteM(MemWriteM), .ByteOpM(ByteOpM),
      .ALUOutM(ALUOutM), .WriteDataM(WriteDataM),
      .ReadDataM(ReadDataM), .MemStallM(MemStallM), .ErrorM(ErrorM),
      .BusAddr(BusAddr), .BusWData(BusWData), .BusBE(BusBE),
      .BusWrite(BusWrite), .BusValid(BusValid),
      .BusReady(BusReady), .BusRData(BusRData), .BusErr(BusErr)
   );

   always #5 clk = ~clk;

   // Issue a request in cycle 0 and check the stall asserts with no bus activity yet.
   task automatic issue(input string tag, input logic wr, input logic bop,
                        input logic [31:0] addr, input logic [31:0] wd);
      @(negedge clk);
      MemReqM = 1'b1; MemWriteM = wr; ByteOpM = bop; ALUOutM = addr; WriteDataM = wd;
      BusReady = 1'b0; BusErr = 1'b0;
      #1;
      n_checks++;
      if ({MemStallM, BusValid, ErrorM} !== 3'b100)
         $display("FAIL %s_c0: stall/valid/err=%b required 100", tag,
                  {MemStallM, BusValid, ErrorM});
      if ({MemStallM, BusValid, ErrorM} !== 3'b100) n_fail++;
   endtask

   task automatic test_reset();
      @(negedge clk);
      reset = 1'b0; MemReqM = 1'b1; MemWriteM = 1'b0; ByteOpM = 1'b0;
      ALUOutM = 32'h100; WriteDataM = 32'h0; BusReady = 1'b1; BusRData = 32'h0; BusErr = 1'b0;
      #1;
      n_checks++;
      if ({MemStallM, BusValid} !== 2'b00) begin
         n_fail++;
         $display("FAIL rst_gate: stall/valid=%b required 00", {MemStallM, BusValid});
      end
      @(negedge clk);
      #1;
      n_checks++;
      if ({ReadDataM, ErrorM, BusAddr, BusWData, BusBE, BusWrite} !== 102'h0) begin
         n_fail++;
         $display("FAIL rst_regs: rd=%h err=%b addr=%h wd=%h be=%b wr=%b required all 0",
                  ReadDataM, ErrorM, BusAddr, BusWData, BusBE, BusWrite);
      end
      @(negedge clk);
      reset = 1'b1; MemReqM = 1'b0; BusReady = 1'b0;
      #1;
      n_checks++;
      if ({MemStallM, BusValid, ErrorM} !== 3'b000) begin
         n_fail++;
         $display("FAIL rst_idle: stall/valid/err=%b required 000",
                  {MemStallM, BusValid, ErrorM});
      end
   endtask

   task automatic test_word_load();
      issue("wl", 1'b0, 1'b0, 32'h100, 32'h0);
      @(negedge clk);
      BusReady = 1'b1; BusRData = 32'hCAFEBABE;
      #1;
      n_checks++;
      if ({BusValid, MemStallM, BusWrite, BusBE, BusAddr} !== {3'b110, 4'hF, 32'h100}) begin
         n_fail++;
         $display("FAIL wl_c1: valid=%b stall=%b wr=%b be=%b addr=%h required 1 1 0 1111 100",
                  BusValid, MemStallM, BusWrite, BusBE, BusAddr);
      end
      @(negedge clk);
      BusReady = 1'b0; BusRData = 32'h0;
      #1;
      n_checks++;
      if ({BusValid, MemStallM, ErrorM, ReadDataM} !== {3'b000, 32'hCAFEBABE}) begin
         n_fail++;
         $display("FAIL wl_c2: valid=%b stall=%b err=%b rd=%h required 0 0 0 cafebabe",
                  BusValid, MemStallM, ErrorM, ReadDataM);
      end
      @(negedge clk);
      MemReqM = 1'b0;
      #1;
      n_checks++;
      if ({BusValid, MemStallM, ErrorM, ReadDataM} !== {3'b000, 32'hCAFEBABE}) begin
         n_fail++;
         $display("FAIL wl_hold: valid=%b stall=%b err=%b rd=%h required 0 0 0 cafebabe",
                  BusValid, MemStallM, ErrorM, ReadDataM);
      end
   endtask

   task automatic test_byte_store();
      issue("bs", 1'b1, 1'b1, 32'h203, 32'h123456A5);
      for (int c = 1; c <= 4; c++) begin
         @(negedge clk);
         BusReady = (c == 4);
         BusRData = 32'hFFFFFFFF;
         #1;
         n_checks++;
         if ({BusValid, BusWrite, MemStallM, BusBE, BusAddr, BusWData} !==
             {3'b111, 4'b1000, 32'h203, 32'hA5A5A5A5}) begin
            n_fail++;
            $display("FAIL bs_c%0d: valid=%b wr=%b stall=%b be=%b addr=%h wd=%h required 1 1 1 1000 203 a5a5a5a5",
                     c, BusValid, BusWrite, MemStallM, BusBE, BusAddr, BusWData);
         end
      end
      @(negedge clk);
      BusReady = 1'b0;
      #1;
      n_checks++;
      if ({BusValid, MemStallM, ErrorM, ReadDataM} !== {3'b000, 32'h0}) begin
         n_fail++;
         $display("FAIL bs_c5: valid=%b stall=%b err=%b rd=%h required 0 0 0 0",
                  BusValid, MemStallM, ErrorM, ReadDataM);
      end
      @(negedge clk);
      MemReqM = 1'b0;
   endtask

   task automatic test_byte_load(input logic [31:0] addr, input logic [31:0] exp_rd);
      issue("bl", 1'b0, 1'b1, addr, 32'h0);
      @(negedge clk);
      BusReady = 1'b1; BusRData = 32'h11223344;
      #1;
      n_checks++;
      if ({BusValid, BusBE, BusAddr} !== {1'b1, 4'b0001 << addr[1:0], addr}) begin
         n_fail++;
         $display("FAIL bl_bus_%h: valid=%b be=%b addr=%h required 1 %b %h",
                  addr, BusValid, BusBE, BusAddr, 4'b0001 << addr[1:0], addr);
      end
      @(negedge clk);
      BusReady = 1'b0;
      #1;
      n_checks++;
      if ({MemStallM, ErrorM, ReadDataM} !== {2'b00, exp_rd}) begin
         n_fail++;
         $display("FAIL bl_rd_%h: stall=%b err=%b rd=%h required 0 0 %h",
                  addr, MemStallM, ErrorM, ReadDataM, exp_rd);
      end
      @(negedge clk);
      MemReqM = 1'b0;
   endtask

   task automatic test_misaligned();
      issue("mis", 1'b0, 1'b0, 32'h102, 32'h0);
      @(negedge clk);
      #1;
      n_checks++;
      if ({BusValid, MemStallM, ErrorM, ReadDataM} !== {3'b001, 32'h0}) begin
         n_fail++;
         $display("FAIL mis_c1: valid=%b stall=%b err=%b rd=%h required 0 0 1 0",
                  BusValid, MemStallM, ErrorM, ReadDataM);
      end
      @(negedge clk);
      MemReqM = 1'b0;
      #1;
      n_checks++;
      if ({BusValid, MemStallM, ErrorM} !== 3'b000) begin
         n_fail++;
         $display("FAIL mis_c2: valid/stall/err=%b required 000", {BusValid, MemStallM, ErrorM});
      end
   endtask

   task automatic test_bus_error();
      issue("be", 1'b0, 1'b0, 32'h40, 32'h0);
      @(negedge clk);
      BusReady = 1'b1; BusErr = 1'b1; BusRData = 32'hFFFFFFFF;
      #1;
      @(negedge clk);
      BusReady = 1'b0; BusErr = 1'b0;
      #1;
      n_checks++;
      if ({MemStallM, ErrorM, ReadDataM} !== {2'b01, 32'h0}) begin
         n_fail++;
         $display("FAIL buserr_c2: stall=%b err=%b rd=%h required 0 1 0",
                  MemStallM, ErrorM, ReadDataM);
      end
      @(negedge clk);
      MemReqM = 1'b0;
      #1;
      n_checks++;
      if (ErrorM !== 1'b0) begin
         n_fail++;
         $display("FAIL buserr_c3: err=%b required 0", ErrorM);
      end
   endtask

   task automatic test_back_to_back();
      issue("b2b_a", 1'b0, 1'b0, 32'h10, 32'h0);
      @(negedge clk);
      BusReady = 1'b1; BusRData = 32'h01020304;
      @(negedge clk);
      BusReady = 1'b0;
      #1;
      n_checks++;
      if (ReadDataM !== 32'h01020304) begin
         n_fail++;
         $display("FAIL b2b_first: rd=%h required 01020304", ReadDataM);
      end
      issue("b2b_b", 1'b0, 1'b0, 32'h14, 32'h0);
      @(negedge clk);
      BusReady = 1'b1; BusRData = 32'h5555AAAA;
      #1;
      n_checks++;
      if ({BusValid, BusAddr} !== {1'b1, 32'h14}) begin
         n_fail++;
         $display("FAIL b2b_addr: valid=%b addr=%h required 1 14", BusValid, BusAddr);
      end
      @(negedge clk);
      BusReady = 1'b0;
      #1;
      n_checks++;
      if ({MemStallM, ReadDataM} !== {1'b0, 32'h5555AAAA}) begin
         n_fail++;
         $display("FAIL b2b_second: stall=%b rd=%h required 0 5555aaaa", MemStallM, ReadDataM);
      end
      @(negedge clk);
      MemReqM = 1'b0;
   endtask

   task automatic test_timeout();
      issue("to", 1'b0, 1'b0, 32'h80, 32'h0);
      for (int c = 1; c <= 4; c++) begin
         @(negedge clk);
         #1;
         n_checks++;
         if ({BusValid, MemStallM, ErrorM} !== 3'b110) begin
            n_fail++;
            $display("FAIL to_c%0d: valid/stall/err=%b required 110", c,
                     {BusValid, MemStallM, ErrorM});
         end
      end
      @(negedge clk);
      #1;
      n_checks++;
      if ({BusValid, MemStallM, ErrorM, ReadDataM} !== {3'b001, 32'h0}) begin
         n_fail++;
         $display("FAIL to_c5: valid=%b stall=%b err=%b rd=%h required 0 0 1 0",
                  BusValid, MemStallM, ErrorM, ReadDataM);
      end
      @(negedge clk);
      MemReqM = 1'b0;
      #1;
      n_checks++;
      if ({BusValid, MemStallM, ErrorM} !== 3'b000) begin
         n_fail++;
         $display("FAIL to_idle: valid/stall/err=%b required 000", {BusValid, MemStallM, ErrorM});
      end
   endtask

   task automatic test_reset_mid_access();
      issue("rm_pre", 1'b0, 1'b0, 32'h30, 32'h0);
      @(negedge clk);
      BusReady = 1'b1; BusRData = 32'h77665544;
      @(negedge clk);
      BusReady = 1'b0;
      @(negedge clk);
      MemReqM = 1'b0;
      issue("rm", 1'b0, 1'b0, 32'h34, 32'h0);
      @(negedge clk);
      #1;
      n_checks++;
      if ({BusValid, ReadDataM} !== {1'b1, 32'h77665544}) begin
         n_fail++;
         $display("FAIL rm_access: valid=%b rd=%h required 1 77665544", BusValid, ReadDataM);
      end
      @(negedge clk);
      reset = 1'b0;
      #1;
      n_checks++;
      if ({BusValid, MemStallM, ErrorM} !== 3'b000) begin
         n_fail++;
         $display("FAIL rm_rstcyc: valid/stall/err=%b required 000", {BusValid, MemStallM, ErrorM});
      end
      @(negedge clk);
      reset = 1'b1; MemReqM = 1'b0;
      #1;
      n_checks++;
      if ({BusValid, MemStallM, ErrorM, ReadDataM} !== {3'b000, 32'h0}) begin
         n_fail++;
         $display("FAIL rm_after: valid=%b stall=%b err=%b rd=%h required 0 0 0 0",
                  BusValid, MemStallM, ErrorM, ReadDataM);
      end
      @(negedge clk);
      #1;
      n_checks++;
      if ({BusValid, ErrorM} !== 2'b00) begin
         n_fail++;
         $display("FAIL rm_noerr: valid/err=%b required 00", {BusValid, ErrorM});
      end
   endtask

   initial begin
      reset = 1'b0; MemReqM = 1'b0; MemWriteM = 1'b0; ByteOpM = 1'b0;
      ALUOutM = 32'h0; WriteDataM = 32'h0; BusReady = 1'b0; BusRData = 32'h0; BusErr = 1'b0;
      test_reset();
      test_word_load();
      test_byte_store();
      test_byte_load(32'h102, 32'h00000022);
      test_byte_load(32'h101, 32'h00000033);
      test_misaligned();
      test_bus_error();
      test_back_to_back();
      test_timeout();
      test_reset_mid_access();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
